param_stack: RTL and testbench
==============================

// Module: param_stack
// PURPOSE
//  Parametrised synchronous LIFO that holds the operand stack of the stack processor.
//  Push, pop and replace (push+pop) operations; one operation accepted per clk.
//  Registered top-of-stack output for zero-latency peek.
//  Registered pop data with a one-cycle pop_valid strobe, which replaces the old popDone pulse.
//  Full/empty/count status and sticky overflow/underflow error flags for the control unit.
// PARAMETERS
//  WIDTH   8     data word width in bits
//  DEPTH   256   number of entries; any value >= 2, need not be a power of 2
//  CNT_W   $clog2(DEPTH+1)   derived localparam, width of count
// PORTS
//  clk        in   1       single clock; all state updates on posedge
//  rst_n      in   1       asynchronous active-low reset
//  push       in   1       push push_data this cycle
//  pop        in   1       pop top entry this cycle
//  push_data  in   WIDTH   word to push
//  dup        in   1       duplicate top (STACK_DUPSWAP_EN only)
//  swap       in   1       exchange top two entries (STACK_DUPSWAP_EN only)
//  err_clr    in   1       clears overflow/underflow
//  top        out  WIDTH   current top-of-stack; 0 when empty
//  pop_data   out  WIDTH   word removed by the last accepted pop
//  pop_valid  out  1       1-cycle strobe, cycle after an accepted pop
//  count      out  CNT_W   current number of entries
//  full       out  1       count == DEPTH
//  empty      out  1       count == 0
//  overflow   out  1       sticky: push was rejected because the stack was full
//  underflow  out  1       sticky: pop/dup/swap was rejected for too few entries
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - count=0, top=0, pop_data=0, pop_valid=0, overflow=0, underflow=0, empty=1, full=0.
//   - Memory contents are not reset and are don't-care.
//   - Reset mid-operation discards any in-flight op; there is no pending state afterwards.
//  Op decode each posedge, highest priority first:
//   push&pop  replace:
//     - pop_data<=top; top<=push_data; count unchanged; pop_valid<=1.
//     - When empty: behaves as a plain push, pop_valid=0, no underflow.
//   push      count<N: mem[count]<=push_data; top<=push_data; count+1.
//             full: rejected, state unchanged, overflow<=1.
//   pop       count>0:
//               - pop_data<=top; count-1; pop_valid<=1.
//               - top<=mem[count-2], or 0 if count==1.
//             empty: rejected, pop_valid=0, underflow<=1.
//   dup       as push of top; full->overflow; empty->underflow.
//   swap      count>=2: exchange mem[count-1] and mem[count-2]; top<=old second; count unchanged.
//             count<2: underflow<=1.
//  Outputs and timing:
//   - pop_valid is high for exactly one cycle per accepted pop or replace.
//   - pop_data holds its value until the next accepted pop.
//   - top, count, full and empty reflect the op on the cycle after the edge; there are no combinational paths from inputs to outputs.
//   - Back-to-back ops every cycle are fully supported, including alternating push and pop at full and at empty.
//  Error flags:
//   - Sticky until err_clr=1.
//   - If err_clr and a new error occur in the same cycle, the error flag wins (is set).
//  Arithmetic:
//   - count never wraps; rejected ops leave mem, top and count untouched.
//   - Data is stored and returned unmodified at WIDTH bits.
// CONFIGURATION
//  STACK_DUPSWAP_EN defined:
//   - dup and swap are decoded with the priority given above.
//  STACK_DUPSWAP_EN undefined:
//   - dup and swap ports remain in the port list but are ignored.
//   - No swap datapath is synthesised.
//   - Behaviour equals push/pop/replace only.
// STRUCTURE
//  stack_pkg:
//   - stack_op_e enum: OP_NONE, OP_PUSH, OP_POP, OP_REPL, OP_DUP, OP_SWAP.
//   - Function to compute CNT_W.
//  Sub-module stack_ram:
//   - DEPTH x WIDTH storage.
//   - 2 write ports are needed for swap: one synchronous write port plus a second enabled under STACK_DUPSWAP_EN.
//   - 2 asynchronous read ports, at count-1 and count-2.
//  param_stack holds:
//   - the op decoder,
//   - the count, top and pop_data registers,
//   - the error flags.
// TESTING
//  1. Reset, then push 0x11,0x22,0x33 -> top=0x33, count=3; pop x3 -> pop_data 0x33,0x22,0x11, each with a 1-cycle pop_valid; empty=1, top=0.
//  2. DEPTH=4: push 5 words -> full=1 after the 4th; 5th sets overflow, top unchanged; err_clr -> overflow=0.
//  3. Pop when empty -> underflow=1, pop_valid stays 0, count=0; reassert rst_n=0 mid-sequence -> all outputs return to reset values asynchronously.
//  4. Push 0xA5, then push=pop=1 with 0x5A -> pop_data=0xA5, pop_valid=1, top=0x5A, count=1.
//  5. STACK_DUPSWAP_EN: push 1,2; swap -> top=1; dup -> count=3, top=1; pops return 1,1,2. Swap with count=1 -> underflow.
//  6. Random push/pop/replace for 10k cycles against a queue model; compare top, count and pop_data every cycle.

Source files
------------

// File: rtl/param_stack_pkg.sv
// Shared types and sizing helpers for the operand stack (param_stack).
// Optional dup/swap support is selected with the STACK_DUPSWAP_EN macro.
package stack_pkg;

    typedef enum logic [2:0] {
        OP_NONE = 3'd0,
        OP_PUSH = 3'd1,
        OP_POP  = 3'd2,
        OP_REPL = 3'd3,
        OP_DUP  = 3'd4,
        OP_SWAP = 3'd5
    } stack_op_e;

    // Count must be able to hold DEPTH itself, hence DEPTH+1 codes.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int addr_width(input int depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/param_stack_if.sv
// Operation/status bundle between the control unit (master) and param_stack (slave).
// No handshake: every cycle the master may request one op, which the stack always takes; status is registered.
interface param_stack_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 256
);
    localparam int CNT_W = stack_pkg::cnt_width(DEPTH);

    logic             push;
    logic             pop;
    logic [WIDTH-1:0] push_data;
    logic             dup;
    logic             swap;
    logic             err_clr;
    logic [WIDTH-1:0] top;
    logic [WIDTH-1:0] pop_data;
    logic             pop_valid;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             empty;
    logic             overflow;
    logic             underflow;

    modport master (
        output push, pop, push_data, dup, swap, err_clr,
        input  top, pop_data, pop_valid, count, full, empty, overflow, underflow
    );

    modport slave (
        input  push, pop, push_data, dup, swap, err_clr,
        output top, pop_data, pop_valid, count, full, empty, overflow, underflow
    );

endinterface

// File: rtl/param_stack_ram.sv
// DEPTH x WIDTH stack storage: two async read ports, one write port, plus a second
// write port for swap that only exists when STACK_DUPSWAP_EN is defined.
module stack_ram #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic             clk,
`ifdef STACK_DUPSWAP_EN
    input  logic             we_b,
    input  logic [AW-1:0]    wb_addr,
    input  logic [WIDTH-1:0] wb_data,
`endif
    input  logic             we_a,
    input  logic [AW-1:0]    wa_addr,
    input  logic [WIDTH-1:0] wa_data,
    input  logic [AW-1:0]    ra_addr,
    output logic [WIDTH-1:0] ra_data,
    input  logic [AW-1:0]    rb_addr,
    output logic [WIDTH-1:0] rb_data
);

    // Contents are deliberately not reset; count alone defines what is valid.
    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_a) begin
            mem_q[wa_addr] <= wa_data;
        end
`ifdef STACK_DUPSWAP_EN
        if (we_b) begin
            mem_q[wb_addr] <= wb_data;
        end
`endif
    end

    assign ra_data = mem_q[ra_addr];
    assign rb_data = mem_q[rb_addr];

endmodule

// File: rtl/param_stack.sv
// Parametrised LIFO operand stack with registered top, pop data and sticky error flags.
// Define STACK_DUPSWAP_EN to decode dup/swap; otherwise those inputs are ignored.
module param_stack
    import stack_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 256
) (
    input  logic         clk,
    input  logic         rst_n,
    param_stack_if.slave bus
);

    localparam int CNT_W = cnt_width(DEPTH);
    localparam int AW    = addr_width(DEPTH);

    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] top_q, top_d;
    logic [WIDTH-1:0] pop_data_q, pop_data_d;
    logic             pop_valid_q, pop_valid_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic             ovf_set, unf_set;

    stack_op_e        op;
    logic             is_full, is_empty;
    logic [AW-1:0]    addr_top, addr_second, addr_next;
    logic             we_a;
    logic [AW-1:0]    wa_addr;
    logic [WIDTH-1:0] wa_data;
    logic [WIDTH-1:0] rd_top, rd_second;
`ifdef STACK_DUPSWAP_EN
    logic             we_b;
    logic [AW-1:0]    wb_addr;
    logic [WIDTH-1:0] wb_data;
`else
    wire              unused_ok = &{1'b0, bus.dup, bus.swap, rd_top};
`endif

    assign is_full  = (count_q == CNT_W'(DEPTH));
    assign is_empty = (count_q == '0);

    // Addresses are clamped to 0 when out of range so the RAM is never indexed past DEPTH-1.
    assign addr_top    = is_empty                  ? '0 : AW'(count_q - CNT_W'(1));
    assign addr_second = (count_q < CNT_W'(2))     ? '0 : AW'(count_q - CNT_W'(2));
    assign addr_next   = is_full                   ? '0 : AW'(count_q);

    always_comb begin
        op = OP_NONE;
        if (bus.push && bus.pop) begin
            op = OP_REPL;
        end else if (bus.push) begin
            op = OP_PUSH;
        end else if (bus.pop) begin
            op = OP_POP;
`ifdef STACK_DUPSWAP_EN
        end else if (bus.dup) begin
            op = OP_DUP;
        end else if (bus.swap) begin
            op = OP_SWAP;
`endif
        end
    end

    always_comb begin
        count_d     = count_q;
        top_d       = top_q;
        pop_data_d  = pop_data_q;
        pop_valid_d = 1'b0;
        ovf_set     = 1'b0;
        unf_set     = 1'b0;
        we_a        = 1'b0;
        wa_addr     = addr_next;
        wa_data     = bus.push_data;
`ifdef STACK_DUPSWAP_EN
        we_b        = 1'b0;
        wb_addr     = addr_second;
        wb_data     = rd_top;
`endif
        unique case (op)
            OP_REPL: begin
                // Replace on an empty stack degenerates to a plain push.
                we_a  = 1'b1;
                top_d = bus.push_data;
                if (is_empty) begin
                    wa_addr = addr_next;
                    count_d = count_q + CNT_W'(1);
                end else begin
                    wa_addr     = addr_top;
                    pop_data_d  = top_q;
                    pop_valid_d = 1'b1;
                end
            end
            OP_PUSH: begin
                if (is_full) begin
                    ovf_set = 1'b1;
                end else begin
                    we_a    = 1'b1;
                    top_d   = bus.push_data;
                    count_d = count_q + CNT_W'(1);
                end
            end
            OP_POP: begin
                if (is_empty) begin
                    unf_set = 1'b1;
                end else begin
                    pop_data_d  = top_q;
                    pop_valid_d = 1'b1;
                    count_d     = count_q - CNT_W'(1);
                    top_d       = (count_q == CNT_W'(1)) ? '0 : rd_second;
                end
            end
`ifdef STACK_DUPSWAP_EN
            OP_DUP: begin
                if (is_empty) begin
                    unf_set = 1'b1;
                end else if (is_full) begin
                    ovf_set = 1'b1;
                end else begin
                    we_a    = 1'b1;
                    wa_data = top_q;
                    count_d = count_q + CNT_W'(1);
                end
            end
            OP_SWAP: begin
                if (count_q < CNT_W'(2)) begin
                    unf_set = 1'b1;
                end else begin
                    we_a    = 1'b1;
                    wa_addr = addr_top;
                    wa_data = rd_second;
                    we_b    = 1'b1;
                    top_d   = rd_second;
                end
            end
`endif
            default: ;
        endcase

        // A new error in the same cycle as err_clr keeps the flag set.
        overflow_d  = ovf_set | (overflow_q  & ~bus.err_clr);
        underflow_d = unf_set | (underflow_q & ~bus.err_clr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q     <= '0;
            top_q       <= '0;
            pop_data_q  <= '0;
            pop_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            top_q       <= top_d;
            pop_data_q  <= pop_data_d;
            pop_valid_q <= pop_valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    stack_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
`ifdef STACK_DUPSWAP_EN
        .we_b    (we_b),
        .wb_addr (wb_addr),
        .wb_data (wb_data),
`endif
        .we_a    (we_a),
        .wa_addr (wa_addr),
        .wa_data (wa_data),
        .ra_addr (addr_top),
        .ra_data (rd_top),
        .rb_addr (addr_second),
        .rb_data (rd_second)
    );

    assign bus.top       = top_q;
    assign bus.pop_data  = pop_data_q;
    assign bus.pop_valid = pop_valid_q;
    assign bus.count     = count_q;
    assign bus.full      = is_full;
    assign bus.empty     = is_empty;
    assign bus.overflow  = overflow_q;
    assign bus.underflow = underflow_q;

endmodule

// File: tb/tb_param_stack.sv
// Self-checking bench for param_stack (DEPTH=4): vector table, corner sequences, random vs queue model.
module tb_param_stack;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    logic clk;
    logic rst_n;

    param_stack_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    param_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_fail   = 0;

    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] m_pd;
    bit               m_pv, m_ovf, m_unf;

    typedef struct {
        bit               push, pop, clr;
        logic [WIDTH-1:0] data;
        logic [WIDTH-1:0] top;
        int               cnt;
        logic [WIDTH-1:0] pd;
        bit               pv, full, empty, ovf, unf;
    } vec_t;

    vec_t vecs[$];

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic void check_outs(input string tag, input logic [WIDTH-1:0] e_top, input int e_cnt,
                                       input logic [WIDTH-1:0] e_pd, input bit e_pv, input bit e_full,
                                       input bit e_empty, input bit e_ovf, input bit e_unf);
        check({tag, " top"},       32'(bus.top),       32'(e_top));
        check({tag, " count"},     32'(bus.count),     32'(e_cnt));
        check({tag, " pop_data"},  32'(bus.pop_data),  32'(e_pd));
        check({tag, " pop_valid"}, 32'(bus.pop_valid), 32'(e_pv));
        check({tag, " full"},      32'(bus.full),      32'(e_full));
        check({tag, " empty"},     32'(bus.empty),     32'(e_empty));
        check({tag, " overflow"},  32'(bus.overflow),  32'(e_ovf));
        check({tag, " underflow"}, 32'(bus.underflow), 32'(e_unf));
    endfunction

    function automatic vec_t mk(input bit p, input bit po, input bit c, input logic [WIDTH-1:0] d,
                                input logic [WIDTH-1:0] t, input int n, input logic [WIDTH-1:0] pd,
                                input bit pv, input bit f, input bit e, input bit o, input bit u);
        vec_t v;
        v.push = p; v.pop = po; v.clr = c; v.data = d;
        v.top = t; v.cnt = n; v.pd = pd; v.pv = pv;
        v.full = f; v.empty = e; v.ovf = o; v.unf = u;
        return v;
    endfunction

    // ---------------- reference model ----------------
    // Stack semantics expressed directly on a queue whose back is the top.
    function automatic void model_step(input bit p, input bit po, input bit d, input bit s,
                                       input bit c, input logic [WIDTH-1:0] data);
        bit ovf_set = 1'b0;
        bit unf_set = 1'b0;
        logic [WIDTH-1:0] a, b;
        m_pv = 1'b0;
        if (p && po) begin
            if (exp_q.size() == 0) begin
                exp_q.push_back(data);
            end else begin
                m_pd = exp_q.pop_back();
                exp_q.push_back(data);
                m_pv = 1'b1;
            end
        end else if (p) begin
            if (exp_q.size() == DEPTH) ovf_set = 1'b1;
            else exp_q.push_back(data);
        end else if (po) begin
            if (exp_q.size() == 0) begin
                unf_set = 1'b1;
            end else begin
                m_pd = exp_q.pop_back();
                m_pv = 1'b1;
            end
`ifdef STACK_DUPSWAP_EN
        end else if (d) begin
            if (exp_q.size() == 0) unf_set = 1'b1;
            else if (exp_q.size() == DEPTH) ovf_set = 1'b1;
            else exp_q.push_back(exp_q[$]);
        end else if (s) begin
            if (exp_q.size() < 2) begin
                unf_set = 1'b1;
            end else begin
                a = exp_q.pop_back();
                b = exp_q.pop_back();
                exp_q.push_back(a);
                exp_q.push_back(b);
            end
`endif
        end
        m_ovf = ovf_set | (m_ovf & ~c);
        m_unf = unf_set | (m_unf & ~c);
    endfunction

    function automatic void model_reset();
        exp_q.delete();
        m_pd = '0; m_pv = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
    endfunction

    function automatic void check_model(input string tag);
        logic [WIDTH-1:0] t;
        t = (exp_q.size() > 0) ? exp_q[$] : '0;
        check_outs(tag, t, exp_q.size(), m_pd, m_pv, exp_q.size() == DEPTH, exp_q.size() == 0, m_ovf, m_unf);
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive_idle();
        bus.push = 1'b0; bus.pop = 1'b0; bus.dup = 1'b0; bus.swap = 1'b0;
        bus.err_clr = 1'b0; bus.push_data = '0;
    endtask

    // Apply one op for one clock; outputs are sampled 1 time unit after the edge.
    task automatic step(input bit p, input bit po, input bit d, input bit s, input bit c,
                        input logic [WIDTH-1:0] data);
        bus.push = p; bus.pop = po; bus.dup = d; bus.swap = s;
        bus.err_clr = c; bus.push_data = data;
        @(posedge clk);
        #1;
        drive_idle();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive_idle();
        @(posedge clk);
        #1;
        check_outs("reset", '0, 0, '0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        rst_n = 1'b1;
        model_reset();
    endtask

    // ---------------- test sequence ----------------
    initial begin
        rst_n = 1'b0;
        drive_idle();
        model_reset();
        #1;
        check_outs("reset_t0", '0, 0, '0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // push/pop/clr, data -> top, count, pop_data, pop_valid, full, empty, overflow, underflow
        vecs.push_back(mk(1,0,0,8'h11, 8'h11,1,8'h00,0,0,0,0,0));
        vecs.push_back(mk(1,0,0,8'h22, 8'h22,2,8'h00,0,0,0,0,0));
        vecs.push_back(mk(1,0,0,8'h33, 8'h33,3,8'h00,0,0,0,0,0));
        vecs.push_back(mk(0,1,0,8'h00, 8'h22,2,8'h33,1,0,0,0,0));
        vecs.push_back(mk(0,1,0,8'h00, 8'h11,1,8'h22,1,0,0,0,0));
        vecs.push_back(mk(0,1,0,8'h00, 8'h00,0,8'h11,1,0,1,0,0));
        vecs.push_back(mk(0,0,0,8'h00, 8'h00,0,8'h11,0,0,1,0,0));
        vecs.push_back(mk(1,0,0,8'h01, 8'h01,1,8'h11,0,0,0,0,0));
        vecs.push_back(mk(1,0,0,8'h02, 8'h02,2,8'h11,0,0,0,0,0));
        vecs.push_back(mk(1,0,0,8'h03, 8'h03,3,8'h11,0,0,0,0,0));
        vecs.push_back(mk(1,0,0,8'h04, 8'h04,4,8'h11,0,1,0,0,0));
        vecs.push_back(mk(1,0,0,8'h05, 8'h04,4,8'h11,0,1,0,1,0));
        vecs.push_back(mk(1,0,1,8'h05, 8'h04,4,8'h11,0,1,0,1,0));
        vecs.push_back(mk(0,0,1,8'h00, 8'h04,4,8'h11,0,1,0,0,0));
        vecs.push_back(mk(0,1,0,8'h00, 8'h03,3,8'h04,1,0,0,0,0));
        vecs.push_back(mk(1,0,0,8'h06, 8'h06,4,8'h04,0,1,0,0,0));
        vecs.push_back(mk(1,1,0,8'h07, 8'h07,4,8'h06,1,1,0,0,0));
        vecs.push_back(mk(0,1,0,8'h00, 8'h03,3,8'h07,1,0,0,0,0));
        vecs.push_back(mk(0,1,0,8'h00, 8'h02,2,8'h03,1,0,0,0,0));
        vecs.push_back(mk(0,1,0,8'h00, 8'h01,1,8'h02,1,0,0,0,0));
        vecs.push_back(mk(0,1,0,8'h00, 8'h00,0,8'h01,1,0,1,0,0));
        vecs.push_back(mk(0,1,0,8'h00, 8'h00,0,8'h01,0,0,1,0,1));
        vecs.push_back(mk(0,1,1,8'h00, 8'h00,0,8'h01,0,0,1,0,1));
        vecs.push_back(mk(0,0,1,8'h00, 8'h00,0,8'h01,0,0,1,0,0));
        vecs.push_back(mk(1,1,0,8'h5A, 8'h5A,1,8'h01,0,0,0,0,0));
        vecs.push_back(mk(0,1,0,8'h00, 8'h00,0,8'h5A,1,0,1,0,0));
        vecs.push_back(mk(1,0,0,8'hA5, 8'hA5,1,8'h5A,0,0,0,0,0));
        vecs.push_back(mk(1,1,0,8'h5A, 8'h5A,1,8'hA5,1,0,0,0,0));
        vecs.push_back(mk(0,1,0,8'h00, 8'h00,0,8'h5A,1,0,1,0,0));

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].push, vecs[i].pop, 1'b0, 1'b0, vecs[i].clr, vecs[i].data);
            check_outs($sformatf("vec%0d", i), vecs[i].top, vecs[i].cnt, vecs[i].pd, vecs[i].pv,
                       vecs[i].full, vecs[i].empty, vecs[i].ovf, vecs[i].unf);
        end

        // Asynchronous reset in the middle of a cycle, with a pop requested.
        step(1,0,0,0,0, 8'h44);
        step(0,1,0,0,0, 8'h00);
        step(0,1,0,0,0, 8'h00);
        step(1,0,0,0,0, 8'h55);
        check_outs("pre_rst", 8'h55, 1, 8'h44, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        bus.pop = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check_outs("async_rst", '0, 0, '0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        drive_idle();
        rst_n = 1'b1;
        step(0,0,0,0,0, 8'h00);
        check_outs("post_rst", '0, 0, '0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

        // dup / swap sequence
        step(1,0,0,0,0, 8'h01);
        step(1,0,0,0,0, 8'h02);
`ifdef STACK_DUPSWAP_EN
        step(0,0,0,1,0, 8'h00);
        check_outs("swap", 8'h01, 2, 8'h00, 0, 0, 0, 0, 0);
        step(0,0,1,0,0, 8'h00);
        check_outs("dup", 8'h01, 3, 8'h00, 0, 0, 0, 0, 0);
        step(0,1,0,0,0, 8'h00);
        check_outs("ds_pop1", 8'h01, 2, 8'h01, 1, 0, 0, 0, 0);
        step(0,1,0,0,0, 8'h00);
        check_outs("ds_pop2", 8'h02, 1, 8'h01, 1, 0, 0, 0, 0);
        step(0,1,0,0,0, 8'h00);
        check_outs("ds_pop3", 8'h00, 0, 8'h02, 1, 0, 1, 0, 0);
        step(1,0,0,0,0, 8'h09);
        step(0,0,0,1,0, 8'h00);
        check_outs("swap_one", 8'h09, 1, 8'h02, 0, 0, 0, 0, 1);
        step(0,0,1,0,1, 8'h00);
        step(0,0,1,0,0, 8'h00);
        step(0,0,1,0,0, 8'h00);
        step(0,0,1,0,0, 8'h00);
        check_outs("dup_full", 8'h09, 4, 8'h02, 0, 1, 0, 1, 0);
`else
        step(0,0,0,1,0, 8'h00);
        check_outs("swap_ign", 8'h02, 2, 8'h00, 0, 0, 0, 0, 0);
        step(0,0,1,0,0, 8'h00);
        check_outs("dup_ign", 8'h02, 2, 8'h00, 0, 0, 0, 0, 0);
        step(0,1,0,0,0, 8'h00);
        check_outs("ds_pop1", 8'h01, 1, 8'h02, 1, 0, 0, 0, 0);
        step(0,1,0,0,0, 8'h00);
        check_outs("ds_pop2", 8'h00, 0, 8'h01, 1, 0, 1, 0, 0);
`endif

        // Randomized traffic against the queue model.
        do_reset();
        for (int cyc = 0; cyc < 10000; cyc++) begin
            bit p, po, d, s, c;
            logic [WIDTH-1:0] data;
            p    = 1'($urandom_range(0, 1));
            po   = 1'($urandom_range(0, 1));
            d    = ($urandom_range(0, 3) == 0);
            s    = ($urandom_range(0, 3) == 0);
            c    = ($urandom_range(0, 15) == 0);
            data = WIDTH'($urandom);
            step(p, po, d, s, c, data);
            model_step(p, po, d, s, c, data);
            check_model($sformatf("rand%0d", cyc));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
